// File: rtl/alu_multicycle.sv
// Parametrised ALU: registered single-cycle ops plus an iterative MUL (and DIV).
// Define ALU_DIV_EN to build the restoring divider on opcode 011.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] Src1,
    input  logic [WIDTH-1:0] Src2,
    input  logic [2:0]       ALU_Control,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [WIDTH-1:0] ALU_Result_Hi,
    output logic             Zero_Flag,
    output logic             Overflow_Flag
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ITER = 1'b1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic [WIDTH:0]   add_s;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res1;
    logic             ovf1;
    logic             iter_op;
    logic             msb;

    assign sum  = Src1 + Src2;
    assign diff = Src1 - Src2;
    assign msb  = Src1[WIDTH-1];

    always_comb begin
        res1 = '0;
        ovf1 = 1'b0;
        unique case (ALU_Control)
            OP_AND: res1 = Src1 & Src2;
            OP_OR:  res1 = Src1 | Src2;
            OP_ADD: begin
                res1 = sum;
                ovf1 = (msb == Src2[WIDTH-1]) && (sum[WIDTH-1] != msb);
            end
            OP_SUB: begin
                res1 = diff;
                ovf1 = (msb != Src2[WIDTH-1]) && (diff[WIDTH-1] != msb);
            end
            OP_SLT: res1 = {{(WIDTH-1){1'b0}}, $signed(Src1) < $signed(Src2)};
            default: res1 = ~(Src1 | Src2);
        endcase
    end

`ifdef ALU_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   sub_s;
    assign iter_op = (ALU_Control == OP_MUL) || (ALU_Control == OP_DIV);
`else
    assign iter_op = (ALU_Control == OP_MUL);
`endif

    // MUL: {hi,lo} holds partial product and the remaining multiplier bits.
    // DIV: hi is the partial remainder, lo shifts dividend out and quotient in.
    always_comb begin
        add_s = {1'b0, hi} + {1'b0, opnd & {WIDTH{lo[0]}}};
        hi_n  = add_s[WIDTH:1];
        lo_n  = {add_s[0], lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        shl   = {hi, lo[WIDTH-1]};
        sub_s = shl - {1'b0, opnd};
        if (div_q) begin
            if (sub_s[WIDTH]) begin
                hi_n = shl[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end else begin
                hi_n = sub_s[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            cnt           <= '0;
            opnd          <= '0;
            hi            <= '0;
            lo            <= '0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            ALU_Result    <= '0;
            ALU_Result_Hi <= '0;
            Zero_Flag     <= 1'b0;
            Overflow_Flag <= 1'b0;
`ifdef ALU_DIV_EN
            div_q         <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start && iter_op) begin
                        state <= ITER;
                        Busy  <= 1'b1;
                        cnt   <= CNT_W'(WIDTH);
                        hi    <= '0;
                        lo    <= Src1;
                        opnd  <= Src2;
`ifdef ALU_DIV_EN
                        div_q <= (ALU_Control == OP_DIV);
`endif
                    end else if (Start) begin
                        Done          <= 1'b1;
                        ALU_Result    <= res1;
                        ALU_Result_Hi <= '0;
                        Zero_Flag     <= (res1 == '0);
                        Overflow_Flag <= ovf1;
                    end
                end
                default: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state         <= IDLE;
                        Busy          <= 1'b0;
                        Done          <= 1'b1;
                        ALU_Result    <= lo_n;
                        ALU_Result_Hi <= hi_n;
                        Zero_Flag     <= (lo_n == '0);
                        Overflow_Flag <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literals.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Start;
    logic [W-1:0] Src1;
    logic [W-1:0] Src2;
    logic [2:0]   ALU_Control;
    logic         Busy;
    logic         Done;
    logic [W-1:0] ALU_Result;
    logic [W-1:0] ALU_Result_Hi;
    logic         Zero_Flag;
    logic         Overflow_Flag;

    alu_multicycle #(.WIDTH(W)) dut (
        .CLK(CLK),
        .RST(RST),
        .Start(Start),
        .Src1(Src1),
        .Src2(Src2),
        .ALU_Control(ALU_Control),
        .Busy(Busy),
        .Done(Done),
        .ALU_Result(ALU_Result),
        .ALU_Result_Hi(ALU_Result_Hi),
        .Zero_Flag(Zero_Flag),
        .Overflow_Flag(Overflow_Flag)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_miss = 0;
    logic checking = 1'b0;

    logic         m_busy, m_done, m_zero, m_ovf;
    logic [W-1:0] m_res, m_hi, p_res, p_hi;
    int           m_left;

    function automatic void calc(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic [W-1:0] h,
                                 output logic ov, output logic lng);
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; h = '0; ov = 1'b0; lng = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                s = sa + sb; r = a + b;
                ov = (s != longint'($signed(r)));
            end
            3'd4: begin
                s = sa - sb; r = a - b;
                ov = (s != longint'($signed(r)));
            end
            3'd5: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0]; h = p[63:32]; lng = 1'b1;
            end
            3'd6: r = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_DIV_EN
            3'd3: begin
                lng = 1'b1;
                if (b == 0) begin r = '1; h = a; end
                else begin r = a / b; h = a % b; end
            end
`endif
            default: r = ~(a | b);
        endcase
    endfunction

    always @(posedge CLK) begin
        logic [W-1:0] r, h;
        logic ov, lng;
        if (RST) begin
            m_busy = 0; m_done = 0; m_res = 0; m_hi = 0;
            m_zero = 0; m_ovf = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_res = p_res; m_hi = p_hi;
                    m_zero = (p_res == 0); m_ovf = 0;
                end
            end else if (Start) begin
                calc(ALU_Control, Src1, Src2, r, h, ov, lng);
                if (lng) begin
                    m_busy = 1; m_left = W; p_res = r; p_hi = h;
                end else begin
                    m_done = 1; m_res = r; m_hi = h;
                    m_zero = (r == 0); m_ovf = ov;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (checking) begin
            n_vec++;
            if (Busy !== m_busy || Done !== m_done || ALU_Result !== m_res ||
                ALU_Result_Hi !== m_hi || Zero_Flag !== m_zero ||
                Overflow_Flag !== m_ovf) begin
                n_miss++;
                $display("FAIL cycle@%0t: got B%b D%b R%h H%h Z%b V%b want B%b D%b R%h H%h Z%b V%b",
                         $time, Busy, Done, ALU_Result, ALU_Result_Hi, Zero_Flag,
                         Overflow_Flag, m_busy, m_done, m_res, m_hi, m_zero, m_ovf);
            end
        end
    end

    task automatic lit(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1; ALU_Control = op; Src1 = a; Src2 = b;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (Done !== 1'b1 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        if (Done !== 1'b1) begin
            n_vec++; n_miss++;
            $display("FAIL timeout: Done not seen after %0d cycles", cyc);
        end
    endtask

    initial begin
        int cyc;
        RST = 1'b1; Start = 1'b0; Src1 = '0; Src2 = '0; ALU_Control = '0;
        repeat (2) @(negedge CLK);
        checking = 1'b1;
        lit("reset_res", ALU_Result, 32'h0);
        lit("reset_busy", {31'd0, Busy}, 32'h0);
        RST = 1'b0;
        @(negedge CLK);

        issue(3'b010, 32'h7FFFFFFF, 32'h00000001);
        lit("add_done", {31'd0, Done}, 32'h1);
        lit("add_res", ALU_Result, 32'h80000000);
        lit("add_ovf", {31'd0, Overflow_Flag}, 32'h1);
        @(negedge CLK);
        lit("add_done_low", {31'd0, Done}, 32'h0);

        issue(3'b100, 32'd5, 32'd5);
        lit("sub_zero", {31'd0, Zero_Flag}, 32'h1);
        issue(3'b110, 32'hFFFFFFFF, 32'h00000001);
        lit("slt_res", ALU_Result, 32'h1);
        issue(3'b000, 32'hF0F0F0F0, 32'hFF00FF00);
        lit("and_res", ALU_Result, 32'hF000F000);
        issue(3'b001, 32'hF0F0F0F0, 32'h0F000001);
        issue(3'b111, 32'h0000FFFF, 32'h00FF0000);
        issue(3'b100, 32'h80000000, 32'h00000001);
        lit("sub_ovf", {31'd0, Overflow_Flag}, 32'h1);

        issue(3'b011, 32'h0F0F0F0F, 32'h00FF00FF);
`ifdef ALU_DIV_EN
        wait_done(cyc);
        lit("div_q", ALU_Result, 32'd15);
        lit("div_r", ALU_Result_Hi, 32'h001E001E);
`else
        lit("op3_nor", ALU_Result, 32'hF000F000);
        lit("op3_done", {31'd0, Done}, 32'h1);
`endif
        @(negedge CLK);

        issue(3'b101, 32'hFFFFFFFF, 32'h00000002);
        wait_done(cyc);
        lit("mul_lat", cyc, 32'd32);
        lit("mul_lo", ALU_Result, 32'hFFFFFFFE);
        lit("mul_hi", ALU_Result_Hi, 32'h00000001);
        issue(3'b010, 32'd1, 32'd1);
        lit("b2b_add", ALU_Result, 32'd2);
        lit("b2b_hi", ALU_Result_Hi, 32'd0);

        issue(3'b101, 32'h00010000, 32'h00030000);
        repeat (5) @(negedge CLK);
        issue(3'b010, 32'h11111111, 32'd1);
        Src1 = 32'hDEADBEEF; ALU_Control = 3'b000;
        wait_done(cyc);
        lit("mul2_lo", ALU_Result, 32'h0);
        lit("mul2_hi", ALU_Result_Hi, 32'h3);
        lit("mul2_zero", {31'd0, Zero_Flag}, 32'h1);
        @(negedge CLK);

        issue(3'b101, 32'd1000, 32'd1000);
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        lit("rst_busy", {31'd0, Busy}, 32'h0);
        lit("rst_hi", ALU_Result_Hi, 32'h0);
        lit("rst_done", {31'd0, Done}, 32'h0);
        repeat (3) @(negedge CLK);
        issue(3'b101, 32'd7, 32'd6);
        wait_done(cyc);
        lit("mul3_lo", ALU_Result, 32'd42);

`ifdef ALU_DIV_EN
        issue(3'b011, 32'd100, 32'd7);
        wait_done(cyc);
        lit("div_lat", cyc, 32'd32);
        lit("div100_q", ALU_Result, 32'd14);
        lit("div100_r", ALU_Result_Hi, 32'd2);
        issue(3'b011, 32'd9, 32'd0);
        wait_done(cyc);
        lit("div0_q", ALU_Result, 32'hFFFFFFFF);
        lit("div0_r", ALU_Result_Hi, 32'd9);
`endif
        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
